// File: rtl/reg_load_seq.sv
// reg_load_seq
// ------------
// Serially loads a seed word into three serial-in shift registers
// (reg_e, reg_c, reg_p) and then runs K warm-up clocks with every register
// shifting. Completion is reported by a one-cycle done pulse.
//
// Handshake: a request is accepted on a rising clk edge where
// start_valid && start_ready. start_ready is high only in IDLE, so at most
// one request is in flight and start_valid outside IDLE is simply ignored.
// The seed is sampled only at that edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start_valid  seed request valid
//   start_ready  high only in IDLE (decoded from state)
//   seed [N]     seed word, captured on handshake
//   abort        (only with REG_LOAD_SEQ_ABORT_EN) return to IDLE, no done
//   load_e/c/p   registered serial data bits to reg_e/reg_c/reg_p
//   shift_e/c/p  registered shift enables
//   busy         high in any state except IDLE (decoded from state)
//   done         registered one-cycle completion pulse
//
// Optional feature macro: REG_LOAD_SEQ_ABORT_EN.
module reg_load_seq #(
  parameter int N   = 64,
  parameter int K   = 40,
  parameter int E_W = 24,
  parameter int C_W = 15,
  parameter int P_W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] seed,
`ifdef REG_LOAD_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         load_e,
  output logic         load_c,
  output logic         load_p,
  output logic         shift_e,
  output logic         shift_c,
  output logic         shift_p,
  output logic         busy,
  output logic         done
);

  localparam int MAX_EC  = (E_W > C_W) ? E_W : C_W;
  localparam int MAX_PK  = (P_W > K) ? P_W : K;
  localparam int MAX_ALL = (MAX_EC > MAX_PK) ? MAX_EC : MAX_PK;
  localparam int CNT_W   = (MAX_ALL + 1 > 1) ? $clog2(MAX_ALL + 1) : 1;

  localparam logic [CNT_W-1:0] E_LAST = CNT_W'(E_W - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_W - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_W - 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'((K > 0) ? K - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_E = 3'd1,
    LOAD_C = 3'd2,
    LOAD_P = 3'd3,
    WARM   = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  // Seed shadow is consumed LSB first: each load cycle presents shadow_q[0]
  // on the next edge and shifts right, so bit i of the seed lands in the
  // i-th load cycle without any variable indexing.
  logic [N-1:0]     shadow_q;

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      load_e   <= 1'b0;
      load_c   <= 1'b0;
      load_p   <= 1'b0;
      shift_e  <= 1'b0;
      shift_c  <= 1'b0;
      shift_p  <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Strobes are registered and default low; each branch raises what the
      // state entered at this edge requires.
      load_e  <= 1'b0;
      load_c  <= 1'b0;
      load_p  <= 1'b0;
      shift_e <= 1'b0;
      shift_c <= 1'b0;
      shift_p <= 1'b0;
      done    <= 1'b0;
`ifdef REG_LOAD_SEQ_ABORT_EN
      if (abort && (state_q != IDLE)) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        shadow_q <= '0;
      end else begin
`endif
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q  <= LOAD_E;
            cnt_q    <= '0;
            shadow_q <= seed >> 1;
            shift_e  <= 1'b1;
            load_e   <= seed[0];
          end
        end
        LOAD_E: begin
          shadow_q <= shadow_q >> 1;
          if (cnt_q == E_LAST) begin
            state_q <= LOAD_C;
            cnt_q   <= '0;
            shift_c <= 1'b1;
            load_c  <= shadow_q[0];
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            shift_e <= 1'b1;
            load_e  <= shadow_q[0];
          end
        end
        LOAD_C: begin
          shadow_q <= shadow_q >> 1;
          if (cnt_q == C_LAST) begin
            state_q <= LOAD_P;
            cnt_q   <= '0;
            shift_p <= 1'b1;
            load_p  <= shadow_q[0];
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            shift_c <= 1'b1;
            load_c  <= shadow_q[0];
          end
        end
        LOAD_P: begin
          if (cnt_q == P_LAST) begin
            cnt_q <= '0;
            if (K == 0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= WARM;
              shift_e <= 1'b1;
              shift_c <= 1'b1;
              shift_p <= 1'b1;
            end
          end else begin
            shadow_q <= shadow_q >> 1;
            cnt_q    <= cnt_q + CNT_ONE;
            shift_p  <= 1'b1;
            load_p   <= shadow_q[0];
          end
        end
        WARM: begin
          if (cnt_q == K_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            shift_e <= 1'b1;
            shift_c <= 1'b1;
            shift_p <= 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          shadow_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
`ifdef REG_LOAD_SEQ_ABORT_EN
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_load_seq.sv
// tb_reg_load_seq
// ---------------
// Directed bench for reg_load_seq. Two instances: dut0 with the default
// K = 40 and dut1 with K = 0. For every accepted request the bench pushes the
// full per-cycle output vector expected from T+1 through the first IDLE
// cycle after done, then pops and compares one entry per clock on the
// falling edge.
//
// Vector layout: {start_ready, busy, shift_e, shift_c, shift_p,
//                 load_e, load_c, load_p, done}
module tb_reg_load_seq;

  localparam int N   = 64;
  localparam int E_W = 24;
  localparam int C_W = 15;
  localparam int P_W = 9;
  localparam int W   = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         sv0, sv1;
  logic [N-1:0] seed;
  logic         abort;

  logic rdy0, ld_e0, ld_c0, ld_p0, sh_e0, sh_c0, sh_p0, busy0, done0;
  logic rdy1, ld_e1, ld_c1, ld_p1, sh_e1, sh_c1, sh_p1, busy1, done1;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_load_seq #(.N(N), .K(40), .E_W(E_W), .C_W(C_W), .P_W(P_W)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(rdy0), .seed(seed),
`ifdef REG_LOAD_SEQ_ABORT_EN
    .abort(abort),
`endif
    .load_e(ld_e0), .load_c(ld_c0), .load_p(ld_p0),
    .shift_e(sh_e0), .shift_c(sh_c0), .shift_p(sh_p0),
    .busy(busy0), .done(done0)
  );

  reg_load_seq #(.N(N), .K(0), .E_W(E_W), .C_W(C_W), .P_W(P_W)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(rdy1), .seed(seed),
`ifdef REG_LOAD_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .load_e(ld_e1), .load_c(ld_c1), .load_p(ld_p1),
    .shift_e(sh_e1), .shift_c(sh_c1), .shift_p(sh_p1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [W-1:0] obs(input int sel);
    if (sel == 0) return {rdy0, busy0, sh_e0, sh_c0, sh_p0, ld_e0, ld_c0, ld_p0, done0};
    else          return {rdy1, busy1, sh_e1, sh_c1, sh_p1, ld_e1, ld_c1, ld_p1, done1};
  endfunction

  function automatic logic [W-1:0] vec(input logic se, sc, sp, le, lc, lp, dn, bz);
    return {~bz, bz, se, sc, sp, le, lc, lp, dn};
  endfunction

  localparam logic [W-1:0] IDLE_V = 9'b1_0000_0000;

  task automatic cmp(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected cycles T+1 .. T+E_W+C_W+P_W+kk+2 (last one is back in IDLE).
  task automatic push_seq(input logic [N-1:0] s, input int kk);
    for (int i = 0; i < E_W; i++) exp_q.push_back(vec(1, 0, 0, s[i], 0, 0, 0, 1));
    for (int j = 0; j < C_W; j++) exp_q.push_back(vec(0, 1, 0, 0, s[E_W+j], 0, 0, 1));
    for (int k = 0; k < P_W; k++) exp_q.push_back(vec(0, 0, 1, 0, 0, s[E_W+C_W+k], 0, 1));
    for (int w = 0; w < kk; w++) exp_q.push_back(vec(1, 1, 1, 0, 0, 0, 0, 1));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 1));
    exp_q.push_back(IDLE_V);
  endtask

  // Presents a request during an IDLE cycle; returns right after the
  // accepting rising edge.
  task automatic do_start(input int sel, input logic [N-1:0] s);
    @(negedge clk);
    seed = s;
    if (sel == 0) sv0 = 1'b1; else sv1 = 1'b1;
    @(posedge clk);
  endtask

  // Compares queued entries one per cycle. With hold set, start_valid stays
  // high and seed keeps changing; the last value is next_seed, which is the
  // one a back-to-back handshake captures.
  task automatic check_run(input string tag, input int sel, input int limit,
                           input bit hold, input logic [N-1:0] next_seed);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge clk);
      cmp(tag, obs(sel), exp_q.pop_front());
      n++;
      if (hold) seed = (exp_q.size() == 0) ? next_seed : {$urandom, $urandom};
      else begin
        sv0 = 1'b0;
        sv1 = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int sel, input int n);
    repeat (n) begin
      @(negedge clk);
      cmp(tag, obs(sel), IDLE_V);
    end
  endtask

  initial begin
    logic [N-1:0] s;
    rst   = 1'b1;
    sv0   = 1'b0;
    sv1   = 1'b0;
    seed  = '0;
    abort = 1'b0;

    // Reset and idle behaviour.
    repeat (2) @(negedge clk);
    cmp("reset_dut0", obs(0), IDLE_V);
    cmp("reset_dut1", obs(1), IDLE_V);
    rst = 1'b0;
    idle_cycles("idle_after_reset", 0, 8);
    idle_cycles("idle_after_reset_k0", 1, 2);

    // Single bit in each field, then all ones and random patterns.
    do_start(0, 64'h1);
    push_seq(64'h1, 40);
    check_run("seed_bit0", 0, 200, 0, '0);

    do_start(0, 64'h0000_0000_0100_0000);
    push_seq(64'h0000_0000_0100_0000, 40);
    check_run("seed_bit24", 0, 200, 0, '0);

    do_start(0, 64'h0000_0080_0000_0000);
    push_seq(64'h0000_0080_0000_0000, 40);
    check_run("seed_bit39", 0, 200, 0, '0);

    do_start(1, {N{1'b1}});
    push_seq({N{1'b1}}, 0);
    check_run("k0_all_ones", 1, 200, 0, '0);

    for (int r = 0; r < 3; r++) begin
      s = {$urandom, $urandom};
      do_start(0, s);
      push_seq(s, 40);
      check_run("random_seed", 0, 200, 0, '0);
    end

    s = {$urandom, $urandom};
    do_start(1, s);
    push_seq(s, 0);
    check_run("k0_random", 1, 200, 0, '0);

    // start_valid held with a changing seed: no second capture while busy,
    // next handshake in the first IDLE cycle after done.
    s = 64'h0123_4567_89AB_CDEF;
    do_start(0, 64'hFFFF_FFFF_0000_5A5A);
    push_seq(64'hFFFF_FFFF_0000_5A5A, 40);
    check_run("hold_valid_first", 0, 200, 1, s);
    @(posedge clk);
    push_seq(s, 40);
    check_run("hold_valid_second", 0, 200, 0, '0);

    // Reset mid-sequence at T+30.
    s = {$urandom, $urandom};
    do_start(0, s);
    push_seq(s, 40);
    check_run("pre_reset", 0, 29, 0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 cmp("async_reset", obs(0), IDLE_V);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles("after_mid_reset", 0, 95);
    do_start(0, s);
    push_seq(s, 40);
    check_run("after_reset_run", 0, 200, 0, '0);

`ifdef REG_LOAD_SEQ_ABORT_EN
    // Abort asserted during cycle T+30.
    s = {$urandom, $urandom};
    do_start(0, s);
    push_seq(s, 40);
    check_run("pre_abort", 0, 30, 0, '0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp("abort_idle", obs(0), IDLE_V);
    exp_q.delete();
    idle_cycles("after_abort", 0, 95);
    abort = 1'b1;
    idle_cycles("abort_in_idle", 0, 2);
    abort = 1'b0;
    do_start(0, s);
    push_seq(s, 40);
    check_run("after_abort_run", 0, 200, 0, '0);
`endif

    idle_cycles("final_idle", 0, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_load_seq.md
Name: reg_load_seq

Overview:
- Sequencer that serially loads a 64-bit seed into the three serial-in shift registers (reg_e 24 b, reg_c 15 b, reg_p 9 b), then runs K warm-up clocks.
- Drives the load_*/shift_* strobes that the controller currently generates for reg_e/reg_c/reg_p.
- Upstream side is a valid/ready request handshake; completion is reported as a one-cycle done pulse.

Parameters:
- N, 64, seed width; must be >= E_W+C_W+P_W.
- K, 40, warm-up clocks after loading; 0 allowed.
- E_W, 24, reg_e length.
- C_W, 15, reg_c length.
- P_W, 9, reg_p length.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  seed request valid.
- start_ready  output  1  high only in IDLE.
- seed  input  N  seed word; captured on handshake.
- load_e  output  1  serial data bit to reg_e.
- load_c  output  1  serial data bit to reg_c.
- load_p  output  1  serial data bit to reg_p.
- shift_e  output  1  shift enable, reg_e.
- shift_c  output  1  shift enable, reg_c.
- shift_p  output  1  shift enable, reg_p.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Single clk; rst asynchronous active-high.
- Reset (any time, including mid-sequence) forces the following, with no partial completion and no done pulse:
  - state = IDLE, counter = 0, seed shadow = 0.
  - load_* = 0, shift_* = 0, busy = 0, done = 0.
  - start_ready = 1 once in IDLE.
- Output timing:
  - load_*, shift_*, done are registered.
  - start_ready and busy decode from state.
- States: IDLE, LOAD_E, LOAD_C, LOAD_P, WARM, DONE.
- IDLE: on start_valid & start_ready (cycle T), capture seed into the shadow register, clear the counter, go to LOAD_E.
- LOAD_E: E_W cycles (T+1..T+E_W).
  - shift_e = 1; load_e = shadow[i], i = 0..E_W-1 (LSB first).
  - Go to LOAD_C.
- LOAD_C: C_W cycles.
  - shift_c = 1; load_c = shadow[E_W+j].
  - Go to LOAD_P.
- LOAD_P: P_W cycles.
  - shift_p = 1; load_p = shadow[E_W+C_W+k].
  - Go to WARM, or to DONE if K = 0.
- WARM: K cycles.
  - shift_e = shift_c = shift_p = 1; all load_* = 0.
  - Go to DONE.
- DONE: one cycle.
  - done = 1, all shift_* = 0.
  - Next state IDLE; start_ready is high again in the following cycle.
- Only one shift_* is high per cycle during the load states; all shift_* are low in IDLE and DONE.
- Seed bits [N-1 : E_W+C_W+P_W] are ignored.
- start_valid outside IDLE is ignored; no queueing. The seed is sampled only at the handshake, so later changes to seed have no effect.
- Default timing (K = 40):
  - shift_e high T+1..T+24.
  - shift_c high T+25..T+39.
  - shift_p high T+40..T+48.
  - WARM T+49..T+88.
  - done at T+89.
- General latency: done at T + E_W + C_W + P_W + K + 1.
- Counter width: clog2(max(E_W, C_W, P_W, K) + 1); the counter resets to 0 on every state change.

Optional Feature:
- Macro: REG_LOAD_SEQ_ABORT_EN.
- Defined: adds input port abort (1 b).
  - In any non-IDLE state, abort = 1 sends the FSM to IDLE at the next edge.
  - All shift_*/load_* are 0 from that edge; no done pulse.
  - abort in IDLE has no effect.
- Undefined: no abort port; every accepted request runs to DONE.

Test Plan:
- Reset release, start_valid = 0 -> start_ready = 1, busy = 0, all shift_*/load_*/done = 0 indefinitely.
- seed = 64'h1, handshake at T -> load_e = 1 only at T+1; shift_e high exactly 24 cycles, shift_c 15, shift_p 9; done at T+89; busy low at T+90.
- seed = 64'h0000_0000_0100_0000 (bit 24) -> load_c = 1 only at T+25; seed = 64'h0000_0080_0000_0000 (bit 39) -> load_p = 1 only at T+40; all other load bits 0.
- K = 0, seed = all ones -> load_* = 1 whenever the matching shift is high; done at T+49; no cycle with all three shifts high.
- start_valid held high with a changing seed during busy -> no second capture; the next handshake occurs the cycle after done (start_ready = 1 at T+90).
- rst pulsed at T+30 -> outputs drop to 0 asynchronously, no done pulse; a new handshake after release gives done exactly 89 cycles later. With REG_LOAD_SEQ_ABORT_EN: abort at T+30 -> all strobes 0 from T+31, start_ready = 1 at T+31.
